// File: rtl/absmax_row_sequencer.sv
// Row absmax sequencer: folds per-beat absolute maxima into one row result,
// records the first beat holding the max, flags outlier rows against a
// threshold and hands each row downstream on a valid/ready channel.
module absmax_row_sequencer #(
    parameter int unsigned MAX_NUM_WIDTH  = 16,
    parameter int unsigned MAX_BEATS      = 64,
    parameter int unsigned BEAT_IDX_WIDTH = $clog2(MAX_BEATS + 1),
    parameter int unsigned ROW_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BEAT_IDX_WIDTH-1:0] cfg_num_beats,
    input  logic [MAX_NUM_WIDTH-1:0]  cfg_threshold,
    input  logic [MAX_NUM_WIDTH-1:0]  beat_max,
    input  logic                      beat_valid,
    output logic                      beat_ready,
    output logic [MAX_NUM_WIDTH-1:0]  row_max,
    output logic [BEAT_IDX_WIDTH-1:0] row_max_idx,
    output logic                      row_outlier,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic                      busy,
    output logic [ROW_CNT_WIDTH-1:0]  rows_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t                    state, state_n;
    logic [BEAT_IDX_WIDTH-1:0] nb, nb_n;
    logic [BEAT_IDX_WIDTH-1:0] cnt, cnt_n;
    logic [BEAT_IDX_WIDTH-1:0] idx, idx_n;
    logic [MAX_NUM_WIDTH-1:0]  thr, thr_n;
    logic [MAX_NUM_WIDTH-1:0]  acc, acc_n;
    logic [MAX_NUM_WIDTH-1:0]  row_max_n;
    logic [BEAT_IDX_WIDTH-1:0] row_max_idx_n;
    logic                      row_outlier_n;
    logic [ROW_CNT_WIDTH-1:0]  rows_done_n;

    logic [BEAT_IDX_WIDTH-1:0] nb_clamped;
    logic                      beat_hs;
    logic                      beat_gt;
    logic [MAX_NUM_WIDTH-1:0]  acc_upd;
    logic [BEAT_IDX_WIDTH-1:0] idx_upd;

    // Handshake-side status is a pure decode of the registered state
    assign beat_ready = (state == IDLE) || (state == ACCUM);
    assign row_valid  = (state == OUTPUT);
    assign busy       = (state != IDLE);
    assign beat_hs    = beat_valid && beat_ready;

    // Beats-per-row clamp: zero means one beat, oversize saturates at MAX_BEATS
    always_comb begin
        nb_clamped = cfg_num_beats;
        if (cfg_num_beats == '0) begin
            nb_clamped = BEAT_IDX_WIDTH'(1);
        end else if (cfg_num_beats > BEAT_IDX_WIDTH'(MAX_BEATS)) begin
            nb_clamped = BEAT_IDX_WIDTH'(MAX_BEATS);
        end
    end

    // Running max update; strict compare keeps the earliest index on ties
    always_comb begin
        beat_gt = beat_max > acc;
        acc_upd = beat_gt ? beat_max : acc;
        idx_upd = beat_gt ? cnt : idx;
    end

    // Next-state and next-register values
    always_comb begin
        state_n       = state;
        nb_n          = nb;
        cnt_n         = cnt;
        idx_n         = idx;
        thr_n         = thr;
        acc_n         = acc;
        row_max_n     = row_max;
        row_max_idx_n = row_max_idx;
        row_outlier_n = row_outlier;
        rows_done_n   = rows_done;
        case (state)
            IDLE: begin
                if (beat_hs) begin
                    nb_n  = nb_clamped;
                    thr_n = cfg_threshold;
                    acc_n = beat_max;
                    idx_n = '0;
                    cnt_n = BEAT_IDX_WIDTH'(1);
                    if (nb_clamped == BEAT_IDX_WIDTH'(1)) begin
                        state_n       = OUTPUT;
                        row_max_n     = beat_max;
                        row_max_idx_n = '0;
                        row_outlier_n = beat_max > cfg_threshold;
                    end else begin
                        state_n = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (beat_hs) begin
                    acc_n = acc_upd;
                    idx_n = idx_upd;
                    cnt_n = cnt + BEAT_IDX_WIDTH'(1);
                    if ((cnt + BEAT_IDX_WIDTH'(1)) == nb) begin
                        state_n       = OUTPUT;
                        row_max_n     = acc_upd;
                        row_max_idx_n = idx_upd;
                        row_outlier_n = acc_upd > thr;
                    end
                end
            end
            OUTPUT: begin
                if (row_ready) begin
                    rows_done_n = rows_done + ROW_CNT_WIDTH'(1);
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial row
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            nb          <= BEAT_IDX_WIDTH'(1);
            cnt         <= '0;
            idx         <= '0;
            thr         <= '0;
            acc         <= '0;
            row_max     <= '0;
            row_max_idx <= '0;
            row_outlier <= 1'b0;
            rows_done   <= '0;
        end else begin
            state       <= state_n;
            nb          <= nb_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            thr         <= thr_n;
            acc         <= acc_n;
            row_max     <= row_max_n;
            row_max_idx <= row_max_idx_n;
            row_outlier <= row_outlier_n;
            rows_done   <= rows_done_n;
        end
    end

endmodule

// File: tb/tb_absmax_row_sequencer.sv
// Scoreboard bench for absmax_row_sequencer: the driver builds each row's
// expected result from the beats it sees accepted, the monitor compares
// whatever the DUT presents on the row channel.
module tb_absmax_row_sequencer;

    localparam int unsigned W   = 16;
    localparam int unsigned MB  = 64;
    localparam int unsigned BIW = $clog2(MB + 1);
    localparam int unsigned RW  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [BIW-1:0] cfg_num_beats;
    logic [W-1:0]   cfg_threshold;
    logic [W-1:0]   beat_max;
    logic           beat_valid;
    logic           beat_ready;
    logic [W-1:0]   row_max;
    logic [BIW-1:0] row_max_idx;
    logic           row_outlier;
    logic           row_valid;
    logic           row_ready;
    logic           busy;
    logic [RW-1:0]  rows_done;

    absmax_row_sequencer #(
        .MAX_NUM_WIDTH (W),
        .MAX_BEATS     (MB),
        .ROW_CNT_WIDTH (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_num_beats (cfg_num_beats),
        .cfg_threshold (cfg_threshold),
        .beat_max      (beat_max),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready),
        .row_max       (row_max),
        .row_max_idx   (row_max_idx),
        .row_outlier   (row_outlier),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .busy          (busy),
        .rows_done     (rows_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]   mx;
        logic [BIW-1:0] idx;
        logic           outl;
        int unsigned    cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            ready_pct = 100;
    logic [RW-1:0] exp_rows;
    bit            seen;
    logic [W-1:0]  pat [0:MB-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_beat();
        case ($urandom_range(5))
            0:       return '0;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return W'($urandom_range(8));
            default: return W'($urandom);
        endcase
    endfunction

    // Drive one row; expected result is the max of accepted beats, first index wins
    task automatic send_row(input int cfg_nb, input int thr, input bit use_pat,
                            input int vpct, input int abort_at);
        int           nb;
        int           got;
        int           guard;
        logic [W-1:0] vals[$];
        exp_t         e;
        bit           v;
        nb    = (cfg_nb == 0) ? 1 : ((cfg_nb > int'(MB)) ? int'(MB) : cfg_nb);
        got   = 0;
        guard = 0;
        while (got < nb) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                $display("FAIL beat_accept_timeout: got %0d beats expected %0d", got, nb);
                errors++;
                $fatal(1, "beat channel stalled");
            end
            if (abort_at > 0 && got == abort_at) begin
                beat_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            v          = ($urandom_range(99) < vpct);
            beat_valid = v;
            beat_max   = use_pat ? pat[got] : rand_beat();
            if (got == 0) begin
                cfg_num_beats = BIW'(cfg_nb);
                cfg_threshold = W'(thr);
            end else begin
                cfg_num_beats = BIW'($urandom);
                cfg_threshold = W'($urandom);
            end
            #1;
            if (got > 0) begin
                chk("accum_busy", 64'(busy), 64'(1));
                chk("accum_beat_ready", 64'(beat_ready), 64'(1));
            end else if (!row_valid) begin
                chk("idle_busy", 64'(busy), 64'(0));
            end
            if (v && beat_ready) begin
                vals.push_back(beat_max);
                got++;
                if (got == nb) begin
                    e.mx  = '0;
                    e.idx = '0;
                    for (int i = 0; i < vals.size(); i++) begin
                        if (vals[i] > e.mx) begin
                            e.mx  = vals[i];
                            e.idx = BIW'(i);
                        end
                    end
                    e.outl = (int'(e.mx) > thr);
                    e.cyc  = cyc + 1;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            beat_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(negedge clk);
            beat_valid = 1'b0;
            n++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
    endtask

    // Monitor: compare presented rows, drive row_ready, track rows_done
    initial begin
        row_ready = 1'b1;
        seen      = 1'b0;
        exp_rows  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                sb.delete();
                exp_rows = '0;
                seen     = 1'b0;
                continue;
            end
            chk("rows_done", 64'(rows_done), 64'(exp_rows));
            chk("beat_ready_vs_row_valid", 64'(beat_ready), 64'(!row_valid));
            if (row_valid) begin
                chk("output_busy", 64'(busy), 64'(1));
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: row_max %0d idx %0d with nothing expected", row_max, row_max_idx);
                end else begin
                    if (!seen) begin
                        chk("latency_cycle", 64'(cyc), 64'(sb[0].cyc));
                        seen = 1'b1;
                    end
                    chk("row_max", 64'(row_max), 64'(sb[0].mx));
                    chk("row_max_idx", 64'(row_max_idx), 64'(sb[0].idx));
                    chk("row_outlier", 64'(row_outlier), 64'(sb[0].outl));
                end
            end
            row_ready = ($urandom_range(99) < ready_pct);
            if (row_valid && row_ready) begin
                exp_rows = exp_rows + RW'(1);
                seen     = 1'b0;
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end
    end

    // Stimulus
    initial begin
        int cfg;
        int thr;
        rst           = 1'b1;
        beat_valid    = 1'b0;
        beat_max      = '0;
        cfg_num_beats = '0;
        cfg_threshold = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_row_valid", 64'(row_valid), 64'(0));
        chk("rst_row_max", 64'(row_max), 64'(0));
        chk("rst_row_max_idx", 64'(row_max_idx), 64'(0));
        chk("rst_row_outlier", 64'(row_outlier), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_beat_ready", 64'(beat_ready), 64'(1));
        chk("rst_rows_done", 64'(rows_done), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic row, ties, threshold equality
        pat[0] = 5;   pat[1] = 200; pat[2] = 17; pat[3] = 3;
        send_row(4, 100, 1'b1, 100, 0);
        pat[0] = 40;  pat[1] = 40;  pat[2] = 12;
        send_row(3, 50, 1'b1, 100, 0);
        pat[0] = 300; pat[1] = 7;
        send_row(2, 300, 1'b1, 100, 0);
        send_row(2, 299, 1'b1, 100, 0);
        wait_drain();

        // Backpressure on a zero-configured (single beat) row
        ready_pct = 0;
        pat[0] = 16'h8000;
        send_row(0, 5, 1'b1, 100, 0);
        idle(6);
        ready_pct = 100;
        wait_drain();

        // Oversized beat count saturates; max sits on the last beat
        for (int i = 0; i < int'(MB); i++) pat[i] = W'(i);
        send_row(int'(MB) + 5, 62, 1'b1, 100, 0);
        wait_drain();

        // Reset mid-row, then a fresh row with gaps in beat_valid
        for (int i = 0; i < 8; i++) pat[i] = W'(1000 - i);
        send_row(8, 0, 1'b1, 100, 3);
        idle(2);
        for (int i = 0; i < 8; i++) pat[i] = W'(10 + (i % 3));
        send_row(8, 11, 1'b1, 50, 0);
        wait_drain();

        // Randomized back-to-back rows
        ready_pct = 60;
        repeat (1000) begin
            cfg = ($urandom_range(9) == 0) ? int'($urandom_range(70)) : int'($urandom_range(1, 12));
            case ($urandom_range(3))
                0:       thr = int'($urandom_range(8));
                1:       thr = 32768;
                default: thr = int'($urandom_range(65535));
            endcase
            send_row(cfg, thr, 1'b0, int'($urandom_range(40, 100)), 0);
            if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
        end
        ready_pct = 100;
        wait_drain();
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
